ahb_led_ctrl: RTL and testbench

AHB_LED_CTRL -- requirements
Module: ahb_led_ctrl

---
 rtl/ahb_led_ctrl.sv | 142 ++++++++++++++
 tb/tb_ahb_led_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_led_ctrl.sv
// AHB-Lite zero-wait-state LED controller: direct levels, per-channel TXEV toggle
// and a shared blink prescaler, all mapped into four 32-bit registers.
module ahb_led_ctrl #(
  parameter int                NUM_CH    = 8,
  parameter int                CNT_WIDTH = 24,
  parameter logic [NUM_CH-1:0] LED_RST   = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  input  logic              i_txev,
  output logic [NUM_CH-1:0] o_led
);

  localparam logic [1:0] A_OUT     = 2'd0;
  localparam logic [1:0] A_TOGEN   = 2'd1;
  localparam logic [1:0] A_BLINKEN = 2'd2;
  localparam logic [1:0] A_PERIOD  = 2'd3;

  logic                 dp_vld_q, dp_vld_d;
  logic                 dp_wr_q, dp_wr_d;
  logic [9:0]           dp_addr_q, dp_addr_d;
  logic [NUM_CH-1:0]    led_q, led_d;
  logic [NUM_CH-1:0]    togen_q, togen_d;
  logic [NUM_CH-1:0]    blinken_q, blinken_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 txev_q;

  logic                 mapped;
  logic                 wr_sel;
  logic                 wr_out, wr_tog, wr_blk, wr_per;
  logic                 txev_rise;
  logic                 tick;
  logic [31:0]          rdata;
  logic                 unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:12], HADDR[1:0], HWDATA};

  // Address phase: only selected NONSEQ/SEQ transfers open a data phase.
  always_comb begin
    dp_vld_d  = HSEL & HREADY & HTRANS[1];
    dp_wr_d   = HWRITE;
    dp_addr_d = HADDR[11:2];
  end

  assign mapped    = (dp_addr_q[9:2] == 8'd0);
  assign wr_sel    = dp_vld_q & dp_wr_q & mapped;
  assign wr_out    = wr_sel & (dp_addr_q[1:0] == A_OUT);
  assign wr_tog    = wr_sel & (dp_addr_q[1:0] == A_TOGEN);
  assign wr_blk    = wr_sel & (dp_addr_q[1:0] == A_BLINKEN);
  assign wr_per    = wr_sel & (dp_addr_q[1:0] == A_PERIOD);
  assign txev_rise = i_txev & ~txev_q;

  // A PERIOD write restarts the prescaler, so it suppresses the tick of that cycle.
  assign tick = (period_q != '0) & (cnt_q == '0) & ~wr_per;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_per) begin
      cnt_d = HWDATA[CNT_WIDTH-1:0];
    end else if (period_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = period_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    togen_d   = wr_tog ? HWDATA[NUM_CH-1:0] : togen_q;
    blinken_d = wr_blk ? HWDATA[NUM_CH-1:0] : blinken_q;
    period_d  = wr_per ? HWDATA[CNT_WIDTH-1:0] : period_q;
  end

  // Per-channel priority: bus write, then blink, then TXEV; at most one toggle.
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_out) begin
        led_d[i] = HWDATA[i];
      end else if (blinken_q[i] & tick) begin
        led_d[i] = ~led_q[i];
      end else if (togen_q[i] & txev_rise) begin
        led_d[i] = ~led_q[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dp_vld_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      led_q     <= LED_RST;
      togen_q   <= '0;
      blinken_q <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      // Track the live level so a TXEV already high at release is not seen as an edge.
      txev_q    <= i_txev;
    end else begin
      dp_vld_q  <= dp_vld_d;
      dp_wr_q   <= dp_wr_d;
      dp_addr_q <= dp_addr_d;
      led_q     <= led_d;
      togen_q   <= togen_d;
      blinken_q <= blinken_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      txev_q    <= i_txev;
    end
  end

  always_comb begin
    rdata = '0;
    if (dp_vld_q & ~dp_wr_q & mapped) begin
      case (dp_addr_q[1:0])
        A_OUT:     rdata[NUM_CH-1:0]    = led_q;
        A_TOGEN:   rdata[NUM_CH-1:0]    = togen_q;
        A_BLINKEN: rdata[NUM_CH-1:0]    = blinken_q;
        default:   rdata[CNT_WIDTH-1:0] = period_q;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign o_led     = led_q;

endmodule

// File: tb/tb_ahb_led_ctrl.sv
// Self-checking bench for ahb_led_ctrl: directed scenarios followed by random
// bus/TXEV traffic, all compared every cycle against a behavioural model.
module tb_ahb_led_ctrl;

  localparam int         NUM_CH    = 8;
  localparam int         CNT_WIDTH = 24;
  localparam logic [7:0] LED_RST   = 8'h5A;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        i_txev;
  logic [7:0]  o_led;

  ahb_led_ctrl #(
    .NUM_CH   (NUM_CH),
    .CNT_WIDTH(CNT_WIDTH),
    .LED_RST  (LED_RST)
  ) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP),
    .i_txev   (i_txev),
    .o_led    (o_led)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [7:0]  m_led  = LED_RST;
  logic [7:0]  m_tog  = '0;
  logic [7:0]  m_blk  = '0;
  logic [23:0] m_per  = '0;
  int          m_k    = 0;      // cycles elapsed since the last PERIOD write
  logic        m_txp  = 1'b0;
  logic        m_pv   = 1'b0;
  logic        m_pw   = 1'b0;
  logic [31:0] m_pa   = '0;
  logic [31:0] nxt_wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check the data-phase read, advance the model, clock, check LEDs.
  task automatic step();
    logic [31:0] exp_rd;
    logic        mapped;
    logic [1:0]  idx;
    logic        wr;
    logic        txr;
    logic        tk;
    logic [7:0]  tmask;
    mapped = (m_pa[11:4] == 8'd0);
    idx    = m_pa[3:2];
    exp_rd = '0;
    if (m_pv && !m_pw && mapped) begin
      case (idx)
        2'd0:    exp_rd = {24'd0, m_led};
        2'd1:    exp_rd = {24'd0, m_tog};
        2'd2:    exp_rd = {24'd0, m_blk};
        default: exp_rd = {8'd0, m_per};
      endcase
    end
    chk("hrdata", HRDATA, exp_rd);
    chk("hreadyout_hresp", {30'd0, HREADYOUT, HRESP}, 32'd2);
    if (i_reset) begin
      m_led = LED_RST; m_tog = '0; m_blk = '0; m_per = '0; m_k = 0;
      m_txp = i_txev;  m_pv = 1'b0; m_pw = 1'b0; m_pa = '0;
    end else begin
      wr  = m_pv && m_pw && mapped;
      txr = i_txev && !m_txp;
      tk  = (m_per != 0) && !(wr && idx == 2'd3) &&
            ((m_k % (int'(m_per) + 1)) == int'(m_per));
      tmask = (m_blk & {8{tk}}) | (m_tog & {8{txr}});
      if (wr && idx == 2'd0) m_led = HWDATA[7:0];
      else                   m_led = m_led ^ tmask;
      if (wr && idx == 2'd1) m_tog = HWDATA[7:0];
      if (wr && idx == 2'd2) m_blk = HWDATA[7:0];
      if (wr && idx == 2'd3) begin
        m_per = HWDATA[23:0];
        m_k   = 0;
      end else begin
        m_k = m_k + 1;
      end
      m_txp = i_txev;
      m_pv  = HSEL && HREADY && HTRANS[1];
      m_pw  = HWRITE;
      m_pa  = HADDR;
    end
    @(posedge clk);
    #1;
    chk("o_led", {24'd0, o_led}, {24'd0, m_led});
  endtask

  task automatic bus(input logic sel, input logic [1:0] tr, input logic w,
                     input logic [31:0] a, input logic [31:0] wd, input logic hr);
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = w;
    HADDR  = a;
    HREADY = hr;
    HSIZE  = 3'($urandom_range(0, 2));
    HWDATA = nxt_wd;
    nxt_wd = wd;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 2'b10, 1'b1, a, d, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1);
  endtask

  task automatic idle();
    bus(1'b0, 2'b00, 1'b0, $urandom, $urandom, 1'b1);
  endtask

  initial begin
    int          tcnt;
    logic        prev;
    logic [31:0] a;
    logic [31:0] d;
    int          op;

    i_reset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = '0; HREADY = 1'b1; i_txev = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle();
    i_reset = 1'b0;
    chk("rst_led", {24'd0, o_led}, {24'd0, LED_RST});
    chk("rst_hrdata", HRDATA, 32'd0);

    // Back-to-back write then read of OUT
    wr(32'h0, 32'h0000_00A5);
    rd(32'h0);
    chk("wr_rd_out_led", {24'd0, o_led}, 32'h0000_00A5);
    chk("wr_rd_out_data", HRDATA, 32'h0000_00A5);
    idle();

    // TXEV toggle on channel 0, two 3-cycle pulses
    wr(32'h0, {24'd0, LED_RST});
    wr(32'h4, 32'h1);
    idle();
    tcnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 6; c++) begin
        i_txev = (c < 3);
        prev   = o_led[0];
        idle();
        if (o_led[0] !== prev) tcnt++;
      end
    end
    chk("txev_toggle_count", tcnt, 32'd2);
    chk("txev_final_led", {24'd0, o_led}, {24'd0, LED_RST});
    wr(32'h4, 32'h0);
    idle();

    // Blink channel 1 with PERIOD = 3, then stop with PERIOD = 0
    wr(32'h8, 32'h2);
    wr(32'hC, 32'h3);
    idle();
    tcnt = 0;
    for (int c = 0; c < 16; c++) begin
      prev = o_led[1];
      idle();
      if (o_led[1] !== prev) tcnt++;
    end
    chk("blink_toggle_count", tcnt, 32'd4);
    wr(32'hC, 32'h0);
    idle();
    tcnt = 0;
    for (int c = 0; c < 12; c++) begin
      prev = o_led[1];
      idle();
      if (o_led[1] !== prev) tcnt++;
    end
    chk("blink_stopped", tcnt, 32'd0);
    wr(32'h8, 32'h0);
    idle();

    // OUT write beats a simultaneous TXEV rise
    wr(32'h0, 32'hFF);
    wr(32'h4, 32'h4);
    wr(32'h8, 32'h4);
    wr(32'hC, 32'h0);
    wr(32'h0, 32'h0);
    i_txev = 1'b1;
    idle();
    chk("write_beats_txev", {24'd0, o_led}, 32'd0);
    i_txev = 1'b0;
    idle();
    i_txev = 1'b1;
    idle();
    chk("txev_after_write", {24'd0, o_led}, 32'h4);

    // Reset during an OUT write data phase; TXEV held high across reset
    wr(32'h0, 32'h0000_00F0);
    i_reset = 1'b1;
    idle();
    i_reset = 1'b0;
    chk("rst_drops_write", {24'd0, o_led}, {24'd0, LED_RST});
    rd(32'h10);
    chk("rd_0x10", HRDATA, 32'd0);
    rd(32'h800);
    chk("rd_0x800", HRDATA, 32'd0);
    idle();
    i_txev = 1'b0;
    idle();

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 3) == 0) i_txev = ~i_txev;
      i_reset = ($urandom_range(0, 149) == 0);
      a = $urandom;
      a[11:4] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      d = (a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 6))
                                                        : $urandom;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: wr(a, d);
        3, 4:    rd(a);
        5:       bus(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), a, d, 1'b1);
        6:       bus(1'b0, 2'b10, 1'($urandom), a, d, 1'b1);
        default: bus(1'b0, 2'b00, 1'b0, a, d, m_pv ? 1'b1 : 1'($urandom));
      endcase
    end
    i_reset = 1'b0;
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
